// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: free-running MCLK plus enable-gated BCLK/LRCLK with clk_in-domain
// strobes and bit index so shifters never have to sample the generated clocks.
module i2s_clk_gen #(
    parameter int MCLK_HALF = 2,
    parameter int BCLK_HALF = 8,
    parameter int SLOT_BITS = 32,
    parameter int BW        = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          en,
    output logic          mclk,
    output logic          bclk,
    output logic          lrclk,
    output logic          bclk_rise_stb,
    output logic          bclk_fall_stb,
    output logic          frame_stb,
    output logic [BW-1:0] bit_idx
);
    localparam int MW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam int CW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [MW-1:0] MTOP = MW'(MCLK_HALF - 1);
    localparam logic [CW-1:0] BTOP = CW'(BCLK_HALF - 1);
    localparam logic [BW-1:0] STOP = BW'(SLOT_BITS - 1);

    if (MCLK_HALF < 1) begin : g_bad_mclk
        $error("i2s_clk_gen: MCLK_HALF must be >= 1");
    end
    if (BCLK_HALF < 1) begin : g_bad_bclk
        $error("i2s_clk_gen: BCLK_HALF must be >= 1");
    end
    if (SLOT_BITS < 2 || SLOT_BITS > 64) begin : g_bad_slot
        $error("i2s_clk_gen: SLOT_BITS must be in 2..64");
    end
    if (BW < $clog2(SLOT_BITS)) begin : g_bad_bw
        $error("i2s_clk_gen: BW too narrow for SLOT_BITS");
    end

    logic [MW-1:0] mclk_cnt_q, mclk_cnt_d;
    logic [CW-1:0] bclk_cnt_q, bclk_cnt_d;
    logic [BW-1:0] bit_idx_q, bit_idx_d;
    logic          mclk_q, mclk_d;
    logic          bclk_q, bclk_d;
    logic          lrclk_q, lrclk_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          frame_q, frame_d;
    logic          mclk_wrap, bclk_wrap, fall_evt, slot_end;

    always_comb begin
        mclk_wrap  = mclk_cnt_q == MTOP;
        mclk_cnt_d = mclk_wrap ? '0 : mclk_cnt_q + MW'(1);
        mclk_d     = mclk_q ^ mclk_wrap;
    end

    // Dropping en returns everything to the start-of-left-slot state in one cycle.
    always_comb begin
        bclk_wrap  = bclk_cnt_q == BTOP;
        fall_evt   = bclk_wrap & bclk_q;
        slot_end   = fall_evt & (bit_idx_q == STOP);
        bclk_cnt_d = (!en || bclk_wrap) ? '0 : bclk_cnt_q + CW'(1);
        bclk_d     = en & (bclk_q ^ bclk_wrap);
        rise_d     = en & bclk_wrap & ~bclk_q;
        fall_d     = en & fall_evt;
        lrclk_d    = en & (lrclk_q ^ slot_end);
        frame_d    = en & slot_end & lrclk_q;
        bit_idx_d  = (!en || slot_end) ? '0 : fall_evt ? bit_idx_q + BW'(1) : bit_idx_q;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mclk_cnt_q <= '0;
            bclk_cnt_q <= '0;
            bit_idx_q  <= '0;
            mclk_q     <= 1'b0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            mclk_cnt_q <= mclk_cnt_d;
            bclk_cnt_q <= bclk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            mclk_q     <= mclk_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            frame_q    <= frame_d;
        end
    end

    assign mclk          = mclk_q;
    assign bclk          = bclk_q;
    assign lrclk         = lrclk_q;
    assign bclk_rise_stb = rise_q;
    assign bclk_fall_stb = fall_q;
    assign frame_stb     = frame_q;
    assign bit_idx       = bit_idx_q;
endmodule

// File: tb/tb_i2s_clk_gen.sv
// tb_i2s_clk_gen: default and minimum-parameter instances checked every cycle
// against an arithmetic model driven by edge counts since reset and since enable.
module tb_i2s_clk_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic a_mclk, a_bclk, a_lrclk, a_rise, a_fall, a_frame;
    logic [4:0] a_idx;
    logic b_mclk, b_bclk, b_lrclk, b_rise, b_fall, b_frame;
    logic [0:0] b_idx;
    logic [13:0] act_a, act_b;
    int pass_cnt = 0;
    int check_cnt = 0;
    int mc = 0;
    int nc = 0;
    int found;

    always #5 clk = ~clk;

    i2s_clk_gen dut_a (
        .clk_in(clk), .rst_n(rst_n), .en(en), .mclk(a_mclk), .bclk(a_bclk),
        .lrclk(a_lrclk), .bclk_rise_stb(a_rise), .bclk_fall_stb(a_fall),
        .frame_stb(a_frame), .bit_idx(a_idx)
    );

    i2s_clk_gen #(.MCLK_HALF(1), .BCLK_HALF(1), .SLOT_BITS(2)) dut_b (
        .clk_in(clk), .rst_n(rst_n), .en(en), .mclk(b_mclk), .bclk(b_bclk),
        .lrclk(b_lrclk), .bclk_rise_stb(b_rise), .bclk_fall_stb(b_fall),
        .frame_stb(b_frame), .bit_idx(b_idx)
    );

    assign act_a = {a_mclk, a_bclk, a_lrclk, a_rise, a_fall, a_frame, 8'(a_idx)};
    assign act_b = {b_mclk, b_bclk, b_lrclk, b_rise, b_fall, b_frame, 8'(b_idx)};

    task automatic chk(input string name, input longint act, input longint exp);
        check_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // m = posedges since reset release, n = consecutive posedges sampled with en=1.
    function automatic logic [13:0] model(input int m, input int n, input int mh, input int bh, input int s);
        int h, p;
        logic rs, fs;
        h  = n / bh;
        p  = n / (2 * bh);
        rs = n > 0 && n % bh == 0 && h % 2 == 1;
        fs = n > 0 && n % bh == 0 && h % 2 == 0;
        return {(m / mh) % 2 == 1, h % 2 == 1, (p / s) % 2 == 1, rs, fs,
                fs && p % (2 * s) == 0, 8'(p % s)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc <= 0;
            nc <= 0;
        end else begin
            mc <= mc + 1;
            nc <= en ? nc + 1 : 0;
        end
    end

    always @(negedge clk) begin
        chk("cycle_a", act_a, model(mc, nc, 2, 8, 32));
        chk("cycle_b", act_b, model(mc, nc, 1, 1, 2));
    end

    // Called at a negedge with the blocks idle; posedge k is the k-th with en=1.
    task automatic measure(input string tag);
        int a_r = 0, a_f = 0, a_i = -1, a_l = 0, a_fr = 0, a_n = 0;
        int b_l = 0, b_fr = 0, b_n = 0;
        en = 1'b1;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            if (a_r == 0 && a_rise) a_r = k;
            if (a_f == 0 && a_fall) begin
                a_f = k;
                a_i = int'(a_idx);
            end
            if (a_l == 0 && a_lrclk) a_l = k;
            if (a_fr == 0 && a_frame) a_fr = k;
            if (b_l == 0 && b_lrclk) b_l = k;
            if (b_fr == 0 && b_frame) b_fr = k;
            a_n += a_frame ? 1 : 0;
            b_n += b_frame ? 1 : 0;
        end
        chk({tag, "_first_rise"}, a_r, 8);
        chk({tag, "_first_fall"}, a_f, 16);
        chk({tag, "_idx_at_fall"}, a_i, 1);
        chk({tag, "_first_lrclk"}, a_l, 512);
        chk({tag, "_first_frame"}, a_fr, 1024);
        chk({tag, "_frame_count"}, a_n, 1);
        chk({tag, "_min_first_lrclk"}, b_l, 4);
        chk({tag, "_min_first_frame"}, b_fr, 8);
        chk({tag, "_min_frame_count"}, b_n, 137);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {act_a, act_b}, 0);
        rst_n = 1'b1;
        repeat (2000) @(negedge clk);
        measure("start");
        found = 0;
        for (int k = 0; k < 3000 && found == 0; k++) begin
            @(negedge clk);
            found = (a_lrclk && a_idx == 5'd10) ? 1 : 0;
        end
        chk("wait_mid_frame", found, 1);
        en = 1'b0;
        @(negedge clk);
        chk("mid_frame_stop", {a_bclk, a_lrclk, a_rise, a_fall, a_frame, a_idx}, 0);
        repeat (5) @(negedge clk);
        measure("reenable");
        found = 0;
        for (int k = 0; k < 3000 && found == 0; k++) begin
            @(negedge clk);
            found = (a_bclk && a_lrclk) ? 1 : 0;
        end
        chk("wait_bclk_lrclk_high", found, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_a", act_a, 0);
        chk("async_reset_b", act_b, 0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        measure("after_reset");
        en = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            en = 1'b1;
            repeat ($urandom_range(1, 1500)) @(negedge clk);
            en = 1'b0;
            repeat ($urandom_range(1, 12)) @(negedge clk);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #($urandom_range(1, 3)) rst_n = 1'b0;
                #1 chk("rand_async_reset", {act_a, act_b}, 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule

// File: doc/i2s_clk_gen.md
Name: i2s_clk_gen

Overview:
Parametrised I2S clock generator. Replaces the fixed divide-by-16 master divider. From the single system clock it derives three clocks:
- MCLK: free-running, for the codec.
- BCLK and LRCLK: start and stop under an enable.
It also produces one-cycle, clk_in-domain strobes and a bit index, so serialiser and deserialiser blocks can shift data without sampling the generated clocks.

Parameters:
MCLK_HALF, 2, clk_in cycles per MCLK half-period (>=1); MCLK = clk_in/(2*MCLK_HALF)
BCLK_HALF, 8, clk_in cycles per BCLK half-period (>=1); BCLK = clk_in/(2*BCLK_HALF)
SLOT_BITS, 32, BCLK periods per channel slot (2..64); LRCLK = BCLK/(2*SLOT_BITS)
BW, $clog2(SLOT_BITS) (min 1), width of bit_idx

Ports:
clk_in  input  1  system clock (50 MHz on DE2)
rst_n  input  1  asynchronous active-low reset
en  input  1  run BCLK/LRCLK; does not affect MCLK
mclk  output  1  codec master clock
bclk  output  1  bit clock
lrclk  output  1  word select, 0 = left slot, 1 = right slot
bclk_rise_stb  output  1  one-cycle pulse, same cycle bclk shows its 0->1 transition
bclk_fall_stb  output  1  one-cycle pulse, same cycle bclk shows its 1->0 transition
frame_stb  output  1  one-cycle pulse, same cycle lrclk shows its 1->0 transition (new frame)
bit_idx  output  BW  BCLK period index within the current slot, 0..SLOT_BITS-1

Behaviour:
- All outputs are registered; no combinational path from en to any output.
- Reset: rst_n low asynchronously clears every register, with no clock needed.
  - Outputs during reset: mclk=0, bclk=0, lrclk=0, all strobes=0, bit_idx=0.
  - Internal counters are also cleared.
- MCLK divider (independent of en):
  - mclk_cnt counts 0..MCLK_HALF-1 on every posedge.
  - On wrap, mclk toggles.
  - First mclk rise is at the MCLK_HALF-th posedge after reset release.
- BCLK divider, evaluated on each posedge with en=1:
  - If bclk_cnt==BCLK_HALF-1: bclk_cnt<=0 and bclk<=~bclk.
  - Otherwise bclk_cnt<=bclk_cnt+1.
- Rising transition (bclk 0->1): bclk_rise_stb<=1.
- Falling transition (bclk 1->0):
  - bclk_fall_stb<=1.
  - If bit_idx==SLOT_BITS-1: bit_idx<=0 and lrclk<=~lrclk. If lrclk was 1, also frame_stb<=1.
  - Otherwise bit_idx<=bit_idx+1.
- Strobe clearing: in every cycle without the corresponding event, the strobe registers load 0. Each pulse is exactly one clk_in cycle wide.
- BCLK_HALF=1: bclk toggles every cycle and rise/fall strobes alternate every cycle. This is legal.
- Enable start: the state at en assertion is defined as the start of the left slot (lrclk=0, bit_idx=0, bclk=0).
  - First bclk rise is at the BCLK_HALF-th posedge sampled with en=1.
  - No frame_stb is issued for this implicit first frame.
  - bit_idx counts BCLK periods after the LRCLK edge. The I2S one-bit MSB delay is the shifter's responsibility, not this block's.
- en deassert (including mid-frame):
  - At the next posedge, synchronously clear bclk, lrclk, bclk_cnt, bit_idx and all strobes to 0.
  - The stop is abrupt, with no slot completion. mclk is unaffected.
- en reasserted: restarts exactly as in the enable-start rule above.
- Clock phase: mclk and bclk have no guaranteed relative phase. Both are divided from clk_in.
- Counter widths: $clog2 of the terminal count (min 1). Counters never exceed their terminal value, so no overflow path exists.
- Elaboration-time checks: out-of-range parameters cause an elaboration error.

Test Plan:
1. Idle clocking: rst_n=0 then released, en=0, defaults -> all outputs 0 during reset. mclk toggles every 2 cycles (12.5 MHz). bclk, lrclk, bit_idx and strobes stay 0 for 2000 cycles.
2. BCLK timing: en=1 sampled at posedge 1 -> bclk rises at posedge 8 with bclk_rise_stb=1 that cycle only. bclk falls at posedge 16 with bclk_fall_stb=1 and bit_idx=1. Period 16 cycles (3.125 MHz), duty 50%.
3. Slot/frame: en held 1 -> lrclk goes 1 at posedge 512 with bit_idx=0. lrclk goes 0 and frame_stb=1 at posedge 1024, then every 1024 cycles (48.83 kHz). Exactly one frame_stb per frame.
4. Mid-frame disable: drop en when lrclk=1, bit_idx=10 -> next posedge bclk=lrclk=bit_idx=0 and no strobes; mclk keeps uninterrupted 4-cycle period. Reassert en -> bclk rises after 8 cycles, and the next lrclk rise lands 512 cycles after re-enable.
5. Minimum params: MCLK_HALF=1, BCLK_HALF=1, SLOT_BITS=2, en=1 -> mclk and bclk are clk_in/2. lrclk period 8 cycles. frame_stb every 8 cycles. bit_idx sequence 0,1,0,1 changing on each fall.
6. Async reset mid-run: drop rst_n between clk_in edges while bclk=1 and lrclk=1 -> all outputs 0 immediately without a clock edge. After release with en=1, restart matches scenario 2.
